// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Bundles the receiver-side write strobe, the consumer-side valid/ready
//   handshake and the status flags of the UART receive buffer.
//   Ports (as seen by the buffer, modport slave):
//     i_data, i_data_stb   - word and single-cycle strobe from the UART receiver
//     o_data, o_valid      - head-of-buffer word and its valid flag
//     i_ready              - consumer accepts o_data this cycle
//     o_count, o_full      - occupancy (0..DEPTH) and full flag
//     o_overflow           - sticky dropped-word flag
//     i_clear_overflow     - clears o_overflow
//   The master modport is the producer/consumer side that drives the inputs.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_data_stb;
  logic [DATA_WIDTH-1:0]    o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_full;
  logic                     o_overflow;
  logic                     i_clear_overflow;

  modport slave (
    input  i_data, i_data_stb, i_ready, i_clear_overflow,
    output o_data, o_valid, o_count, o_full, o_overflow
  );

  modport master (
    output i_data, i_data_stb, i_ready, i_clear_overflow,
    input  o_data, o_valid, o_count, o_full, o_overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side circular buffer behind a UART receiver. Words arrive on a
//   single-cycle strobe with no back-pressure, are stored in a power-of-two
//   ring, and leave through a valid/ready handshake. Occupancy and a sticky
//   overflow flag let software notice dropped words.
//   Ports:
//     i_clk    - system clock
//     i_reset  - asynchronous, active-high reset
//     bus      - uart_rx_fifo_if.slave (data in/out, handshake, status)
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input logic           i_clk,
  input logic           i_reset,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;

  logic empty;
  logic ptrFull;
  logic push;
  logic pop;
  logic drop;

  // The extra pointer MSB separates "same slot, empty" from "same slot, full".
  // A pop in the same cycle frees a slot, so a strobe while full is still
  // accepted then; only a strobe while full without a pop is dropped.
  always_comb begin
    empty   = (wrPtr_q == rdPtr_q);
    ptrFull = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    pop     = !empty && bus.i_ready;
    push    = bus.i_data_stb && (!ptrFull || pop);
    drop    = bus.i_data_stb && ptrFull && !pop;
  end

  always_comb begin
    wrPtr_d = push ? wrPtr_q + PW'(1) : wrPtr_q;
    rdPtr_d = pop  ? rdPtr_q + PW'(1) : rdPtr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == PW'(DEPTH));

    // A new overflow wins over a same-cycle clear request.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.i_clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define
  // which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wrPtr_q[AW-1:0]] <= bus.i_data;
    end
  end

  assign bus.o_data     = empty ? '0 : mem_q[rdPtr_q[AW-1:0]];
  assign bus.o_valid    = !empty;
  assign bus.o_count    = count_q;
  assign bus.o_full     = full_q;
  assign bus.o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo. A queue-based reference model
//   tracks the expected contents; words accepted by the model are pushed
//   into a scoreboard queue and a separate monitor pops and compares them
//   whenever the DUT hands a word to the consumer.
module tb_uart_rx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic clk;
  logic rst;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] expQ [$];
  int            modelCount = 0;
  logic          modelOverflow = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every handshake-complete cycle must deliver the oldest
  // outstanding accepted word.
  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (expQ.size() == 0) begin
        check("unexpectedWord", {16'h0, bus.o_data}, 32'hFFFF_FFFF);
      end else begin
        check("popData", {16'h0, bus.o_data}, {16'h0, expQ.pop_front()});
      end
    end
  end

  // Compares registered status against the model as it stands before the
  // upcoming edge; head data is compared only when no pop is in flight.
  task automatic checkOutput();
    check("count",    32'(bus.o_count),    32'(modelCount));
    check("valid",    32'(bus.o_valid),    32'(modelCount > 0));
    check("full",     32'(bus.o_full),     32'(modelCount == DEPTH));
    check("overflow", 32'(bus.o_overflow), 32'(modelOverflow));
    if (modelCount == 0) begin
      check("emptyData", {16'h0, bus.o_data}, 32'h0);
    end else if (!bus.i_ready) begin
      check("headData", {16'h0, bus.o_data}, {16'h0, expQ[0]});
    end
  endtask

  // Drives one cycle of inputs (called just after a rising edge), updates
  // the model from the buffer's rules, and leaves time just after the
  // next rising edge.
  task automatic applyStimulus(input logic stb, input logic [DW-1:0] data,
                               input logic ready, input logic clr);
    bit popWill;
    bit accept;
    bus.i_data_stb       = stb;
    bus.i_data           = data;
    bus.i_ready          = ready;
    bus.i_clear_overflow = clr;
    popWill = (modelCount > 0) && ready;
    accept  = stb && ((modelCount < DEPTH) || popWill);
    if (accept) expQ.push_back(data);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    modelCount = modelCount + int'(accept) - int'(popWill);
    if (stb && !accept) modelOverflow = 1'b1;
    else if (clr)       modelOverflow = 1'b0;
  endtask

  task automatic drainAll();
    for (int i = 0; i < DEPTH + 4 && modelCount > 0; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end
    check("drainedQueue", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.i_data           = '0;
    bus.i_data_stb       = 1'b0;
    bus.i_ready          = 1'b0;
    bus.i_clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("resetCount", 32'(bus.o_count), 32'd0);
    check("resetValid", 32'(bus.o_valid), 32'd0);
    check("resetData",  {16'h0, bus.o_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First-word latency.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("latencyData", {16'h0, bus.o_data}, 32'h1234);
    drainAll();

    // Fill to full, then drain in order.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("fullFlag", 32'(bus.o_full), 32'd1);
    drainAll();

    // Overflow while full, sticky until cleared.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DW'(16'h0100 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("overflowSet", 32'(bus.o_overflow), 32'd1);
    drainAll();
    check("overflowSticky", 32'(bus.o_overflow), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("overflowCleared", 32'(bus.o_overflow), 32'd0);

    // Strobe while full with a same-cycle pop is accepted.
    for (int i = 1; i <= DEPTH; i++) applyStimulus(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("fullPushPopNoOverflow", 32'(bus.o_overflow), 32'd0);
    check("fullPushPopCount", 32'(bus.o_count), 32'(DEPTH));
    drainAll();

    // Pointer wrap with push-then-pop pairs.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
      check("wrapCountMax", 32'(bus.o_count <= 1), 32'd1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
    end

    // Randomized traffic including overflows and clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, DW'($urandom),
                    $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8);
    end
    drainAll();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between edges discards contents.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
    #2;
    rst            = 1'b1;
    bus.i_data_stb = 1'b1;
    bus.i_data     = 16'h0055;
    #1;
    check("asyncResetValid",    32'(bus.o_valid),    32'd0);
    check("asyncResetCount",    32'(bus.o_count),    32'd0);
    check("asyncResetOverflow", 32'(bus.o_overflow), 32'd0);
    expQ.delete();
    modelCount    = 0;
    modelOverflow = 1'b0;
    @(posedge clk);
    #1;
    bus.i_data_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    check("postResetHead", {16'h0, bus.o_data}, 32'h00AA);
    drainAll();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver. It captures each word presented with a single-cycle valid strobe (no back-pressure is possible on that side) into a power-of-two circular buffer. It presents the words to the consumer (CPU bus bridge or command decoder) over a valid/ready interface. It reports occupancy and a sticky overflow flag so software can detect dropped words.

Parameters:
DATA_WIDTH, 16, width of each received word; matches the receiver word width.
DEPTH, 16, number of buffer entries; power of two, minimum 2.

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_data  input  DATA_WIDTH  word from the receiver
i_data_stb  input  1  single-cycle strobe; i_data is valid in this cycle
o_data  output  DATA_WIDTH  head-of-buffer word
o_valid  output  1  buffer is non-empty; o_data is valid
i_ready  input  1  consumer accepts o_data this cycle
o_count  output  $clog2(DEPTH)+1  current number of stored words, 0..DEPTH
o_full  output  1  o_count == DEPTH
o_overflow  output  1  sticky: a strobed word was dropped
i_clear_overflow  input  1  clears o_overflow

Behaviour:
- Clock and reset: single clock domain on i_clk. i_reset is asynchronous and active-high; its assertion takes effect immediately.
- Reset values: write and read pointers 0, o_count 0, o_valid 0, o_full 0, o_overflow 0, o_data 0. Storage array contents are not reset.
- Pointers: $clog2(DEPTH)+1 bits wide. The low bits index storage. The MSB distinguishes full from empty. Both pointers wrap naturally modulo 2*DEPTH.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- Push: occurs when i_data_stb=1 and the buffer is not full, or when it is full and a pop happens in the same cycle.
  - i_data is written at the write pointer.
  - The write pointer increments at the clock edge.
- Pop: occurs when o_valid=1 and i_ready=1. The read pointer increments at the clock edge.
- o_data: combinational read of storage at the read pointer, gated to 0 when empty. o_valid = not empty.
- Latency: a word strobed in cycle N has o_valid=1 and o_data equal to that word in cycle N+1, if the buffer was empty. It is never visible in cycle N itself; there is no bypass.
- o_count: registered.
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
- Simultaneous push and pop:
  - Not full: both occur; count unchanged.
  - Full: the pop frees a slot, so the push is accepted; no overflow; count stays DEPTH.
  - Empty: no pop is possible (o_valid=0); only the push occurs.
- Overflow: i_data_stb=1 while full without a same-cycle pop.
  - The word is dropped; pointers and storage are unchanged.
  - o_overflow is set at the next edge.
  - If i_clear_overflow is asserted in the same cycle as a new overflow, set wins.
  - i_clear_overflow otherwise clears o_overflow at the next edge.
- i_ready while empty: ignored; nothing changes.
- Reset mid-operation: all stored words are discarded (pointers cleared). A strobe coincident with reset is dropped.
- No internal state machine beyond the pointer, count and overflow registers. All outputs except o_data and o_valid come directly from registers.

Test Plan:
- Reset, then strobe 0x1234 with i_ready=0 -> next cycle o_valid=1, o_data=0x1234, o_count=1, o_full=0, o_overflow=0.
- Strobe 0x0001..0x0010 (16 words, DEPTH=16) with i_ready=0 -> o_full=1, o_count=16. Then pop all with i_ready=1 -> data emerges 0x0001..0x0010 in order, one per cycle; o_valid falls after the last; o_count=0.
- Fill to 16, then strobe 0xDEAD with i_ready=0 -> o_overflow=1, o_count=16. Drain -> 0xDEAD never appears. Pulse i_clear_overflow -> o_overflow=0 the next cycle.
- Full buffer, strobe 0xBEEF in the same cycle as a pop -> no overflow, o_count stays 16. 0xBEEF is the last word drained after the 15 remaining originals.
- Pointer wrap: 40 iterations of push-then-pop of 0x0000..0x0027 -> every word is returned intact in order, and o_count never exceeds 1.
- Load 5 words, assert i_reset asynchronously between clock edges -> o_valid, o_count and o_overflow are 0 immediately. After release, a new strobe of 0x00AA is the first word out.
